// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Push-button front end. Synchronises the raw button level,
//               debounces it with a four-state FSM, and produces a clean
//               level, single-cycle press/release strobes, an optional
//               auto-repeat on long holds, and a wrapping count of confirmed
//               presses.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    input  logic       repeat_en,
    output logic       clean,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic [7:0] press_count
);

    // ------------------------------------------------------------------------
    // Derived widths and terminal counts
    // ------------------------------------------------------------------------
    localparam int c_DEB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int c_HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES
                                                              : REPEAT_CYCLES;
    localparam int c_HOLD_W   = $clog2(c_HOLD_MAX);

    localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_REP_LAST  = c_HOLD_W'(REPEAT_CYCLES - 1);

    // clean is high exactly in the two states where the button is accepted
    // as pressed; the encoding keeps that decode to a single bit.
    typedef enum logic [1:0] {
        ST_IDLE         = 2'b00,
        ST_PRESS_WAIT   = 2'b01,
        ST_HELD         = 2'b10,
        ST_RELEASE_WAIT = 2'b11
    } state_t;

    // ------------------------------------------------------------------------
    // State and next-state signals
    // ------------------------------------------------------------------------
    logic                s1_q;
    logic                sync_q;
    state_t              state_q,    state_d;
    logic [c_DEB_W-1:0]  deb_cnt_q,  deb_cnt_d;
    logic [c_HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic                rep_phase_q, rep_phase_d;   // 0: waiting for first repeat
    logic                press_q,    press_d;
    logic                release_q,  release_d;
    logic                clean_q,    clean_d;
    logic [7:0]          count_q,    count_d;

    logic                w_deb_done;
    logic                w_rep_fire;

    // ------------------------------------------------------------------------
    // Two-flop synchroniser; everything downstream sees only sync_q
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            s1_q   <= btn_in;
            sync_q <= s1_q;
        end
    end

    // Debounce window complete / auto-repeat interval complete
    assign w_deb_done = (deb_cnt_q == c_DEB_LAST);
    assign w_rep_fire = rep_phase_q ? (hold_cnt_q == c_REP_LAST)
                                    : (hold_cnt_q == c_HOLD_LAST);

    // ------------------------------------------------------------------------
    // Next-state, counter and strobe logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        rep_phase_d = rep_phase_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        count_d     = count_q;

        case (state_q)
            ST_IDLE: begin
                deb_cnt_d   = '0;
                hold_cnt_d  = '0;
                rep_phase_d = 1'b0;
                if (sync_q) begin
                    state_d = ST_PRESS_WAIT;
                end
            end

            ST_PRESS_WAIT: begin
                hold_cnt_d  = '0;
                rep_phase_d = 1'b0;
                if (!sync_q) begin
                    // Bounce: abandon the attempt silently.
                    state_d   = ST_IDLE;
                    deb_cnt_d = '0;
                end else if (w_deb_done) begin
                    state_d   = ST_HELD;
                    deb_cnt_d = '0;
                    press_d   = 1'b1;
                    count_d   = count_q + 8'd1;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end

            ST_HELD: begin
                deb_cnt_d = '0;
                if (!sync_q) begin
                    state_d     = ST_RELEASE_WAIT;
                    hold_cnt_d  = '0;
                    rep_phase_d = 1'b0;
                end else if (!repeat_en) begin
                    // Repeat disabled: park the timer in first-repeat phase.
                    hold_cnt_d  = '0;
                    rep_phase_d = 1'b0;
                end else if (w_rep_fire) begin
                    press_d     = 1'b1;
                    hold_cnt_d  = '0;
                    rep_phase_d = 1'b1;
                end else begin
                    hold_cnt_d  = hold_cnt_q + 1'b1;
                end
            end

            ST_RELEASE_WAIT: begin
                hold_cnt_d  = '0;
                rep_phase_d = 1'b0;
                if (sync_q) begin
                    // Release bounce: fall back to HELD, no strobe.
                    state_d   = ST_HELD;
                    deb_cnt_d = '0;
                end else if (w_deb_done) begin
                    state_d   = ST_IDLE;
                    deb_cnt_d = '0;
                    release_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                deb_cnt_d   = '0;
                hold_cnt_d  = '0;
                rep_phase_d = 1'b0;
            end
        endcase

        clean_d = (state_d == ST_HELD) || (state_d == ST_RELEASE_WAIT);
    end

    // ------------------------------------------------------------------------
    // State, counter and registered-output update
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            rep_phase_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            clean_q     <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            rep_phase_q <= rep_phase_d;
            press_q     <= press_d;
            release_q   <= release_d;
            clean_q     <= clean_d;
            count_q     <= count_d;
        end
    end

    assign clean         = clean_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign press_count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Scoreboard bench for button_conditioner with D=4, HOLD=10,
//               REPEAT=3. Stimulus pushes the expected strobes (cycle, kind,
//               press_count); a monitor pops one entry per observed strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int c_D    = 4;
    localparam int c_HOLD = 10;
    localparam int c_REP  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_in;
    logic       repeat_en;
    logic       clean;
    logic       press_pulse;
    logic       release_pulse;
    logic [7:0] press_count;

    button_conditioner #(
        .DEBOUNCE_CYCLES (c_D),
        .HOLD_CYCLES     (c_HOLD),
        .REPEAT_CYCLES   (c_REP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_in        (btn_in),
        .repeat_en     (repeat_en),
        .clean         (clean),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        bit         is_press;
        logic [7:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    int         cyc        = 0;
    int         n_cmp      = 0;
    int         n_bad      = 0;
    int         press_seen = 0;
    int         rel_seen   = 0;
    logic       prev_press = 1'b0;
    logic [7:0] model_cnt  = 8'd0;

    // Rising-edge counter: during the cycle after edge E, cyc == E.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int req);
        n_cmp = n_cmp + 1;
        if (act !== req) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        if (press_pulse || release_pulse) begin
            check("pulse_exclusive", int'(press_pulse & release_pulse), 0);
            if (press_pulse) begin
                check("press_not_back_to_back", int'(prev_press), 0);
                press_seen = press_seen + 1;
            end
            if (release_pulse) rel_seen = rel_seen + 1;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse_press", int'(press_pulse), -1);
            end else begin
                e = exp_q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_kind_is_press", int'(press_pulse), int'(e.is_press));
                check("pulse_press_count", int'(press_count), int'(e.cnt));
            end
        end
        prev_press = press_pulse;
    end

    // Hold btn at v for n rising edges; returns just after a falling edge.
    task automatic drive(input logic v, input int n);
        btn_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int at, input bit p, input logic [7:0] c);
        exp_t x;
        x.cyc = at; x.is_press = p; x.cnt = c;
        exp_q.push_back(x);
    endtask

    // Clean press from IDLE: strobe 2 sync + D debounce edges after rise.
    task automatic do_press();
        model_cnt = model_cnt + 8'd1;
        push(cyc + c_D + 3, 1'b1, model_cnt);
        drive(1'b1, 10);
    endtask

    task automatic do_release();
        push(cyc + c_D + 3, 1'b0, model_cnt);
        drive(1'b0, 10);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_cnt = 8'd0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    int base;

    initial begin
        reset = 1'b1; btn_in = 1'b0; repeat_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_clean", int'(clean), 0);
        check("reset_press", int'(press_pulse), 0);
        check("reset_release", int'(release_pulse), 0);
        check("reset_count", int'(press_count), 0);
        reset = 1'b0;
        drive(1'b0, 3);

        // Clean press: strobe only in the cycle after edge k+6.
        base = cyc;
        model_cnt = 8'd1;
        push(base + 7, 1'b1, 8'd1);
        drive(1'b1, 6);
        check("t1_clean_before", int'(clean), 0);
        drive(1'b1, 1);
        check("t1_clean_after", int'(clean), 1);
        check("t1_count", int'(press_count), 1);
        drive(1'b1, 5);

        // Release bounce: clean stays 1, single release after final fall.
        drive(1'b0, 2);
        check("t3_clean_bounce_lo", int'(clean), 1);
        drive(1'b1, 2);
        check("t3_clean_bounce_hi", int'(clean), 1);
        push(cyc + 7, 1'b0, 8'd1);
        drive(1'b0, 6);
        check("t3_clean_before_release", int'(clean), 1);
        drive(1'b0, 1);
        check("t3_clean_after_release", int'(clean), 0);
        drive(1'b0, 4);

        // Glitch rejection: 3 high, 1 low, then steady high.
        do_reset();
        drive(1'b0, 3);
        drive(1'b1, 3);
        drive(1'b0, 1);
        check("t2_clean_glitch", int'(clean), 0);
        model_cnt = 8'd1;
        push(cyc + 7, 1'b1, 8'd1);
        drive(1'b1, 10);
        check("t2_clean", int'(clean), 1);
        check("t2_count", int'(press_count), 1);
        do_release();

        // Auto-repeat: press at +7, repeats at +10,+13,...,+37 after it.
        do_reset();
        drive(1'b0, 3);
        repeat_en = 1'b1;
        base = cyc;
        model_cnt = 8'd1;
        push(base + 7, 1'b1, 8'd1);
        for (int r = 0; r < 10; r++) push(base + 7 + c_HOLD + c_REP * r, 1'b1, 8'd1);
        drive(1'b1, 44);
        check("t4_count_after_repeats", int'(press_count), 1);
        push(cyc + 7, 1'b0, 8'd1);
        drive(1'b0, 10);
        repeat_en = 1'b0;
        check("t4_queue_drained", exp_q.size(), 0);

        // Wrap-around: 256 press/release cycles.
        do_reset();
        drive(1'b0, 3);
        press_seen = 0;
        rel_seen   = 0;
        for (int i = 0; i < 256; i++) begin
            do_press();
            do_release();
        end
        check("t5_count_wrapped", int'(press_count), 0);
        check("t5_press_pulses", press_seen, 256);
        check("t5_release_pulses", rel_seen, 256);

        // Reset during PRESS_WAIT with button held.
        drive(1'b1, 4);
        reset = 1'b1;
        @(negedge clk);
        check("t6a_clean", int'(clean), 0);
        check("t6a_press", int'(press_pulse), 0);
        check("t6a_count", int'(press_count), 0);
        reset = 1'b0;
        model_cnt = 8'd1;
        push(cyc + 7, 1'b1, 8'd1);
        drive(1'b1, 10);
        check("t6a_count_after", int'(press_count), 1);

        // Reset during HELD with button held.
        reset = 1'b1;
        @(negedge clk);
        check("t6b_clean", int'(clean), 0);
        check("t6b_press", int'(press_pulse), 0);
        check("t6b_release", int'(release_pulse), 0);
        check("t6b_count", int'(press_count), 0);
        reset = 1'b0;
        model_cnt = 8'd1;
        push(cyc + 7, 1'b1, 8'd1);
        drive(1'b1, 10);
        check("t6b_count_after", int'(press_count), 1);
        do_release();

        drive(1'b0, 10);
        check("final_queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_conditioner.md
# button_conditioner

Front-end conditioner for a mechanical push-button, sitting directly upstream of the ripple and modulo counter stages. It takes the raw asynchronous button level and synchronises and debounces it. It produces a clean level, single-cycle press/release pulses usable as counter clock-enables, an optional auto-repeat, and a running count of confirmed presses. Everything runs on one free-running clock.

## Interface
- DEBOUNCE_CYCLES, default 1000000: consecutive stable synchronised samples required to accept a level change (10 ms at 100 MHz); legal range ≥ 2.
- HOLD_CYCLES, default 50000000: cycles in HELD from the initial press_pulse to the first auto-repeat pulse; legal range ≥ 2.
- REPEAT_CYCLES, default 10000000: spacing between subsequent auto-repeat pulses; legal range ≥ 2.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_in  input  1  raw button level; asynchronous and bouncy.
- repeat_en  input  1  enables auto-repeat while the button is held.
- clean  output  1  debounced button level.
- press_pulse  output  1  one-cycle strobe on a confirmed press or an auto-repeat.
- release_pulse  output  1  one-cycle strobe on a confirmed release.
- press_count  output  8  number of confirmed presses; wraps modulo 256; excludes repeats.

## Operation
- **Synchroniser:** two flops, btn_in → s1 → btn_sync. The FSM and counters see only btn_sync.
- **Debounce counter:** width clog2(DEBOUNCE_CYCLES). Cleared on every FSM state change.
- **Hold counter:** width clog2(max(HOLD_CYCLES, REPEAT_CYCLES)).
- **FSM states:** IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - **IDLE** (clean=0): btn_sync=1 → PRESS_WAIT with debounce count=0.
  - **PRESS_WAIT** (clean=0):
    - btn_sync=0 → IDLE. This is a rejected bounce: no pulse.
    - btn_sync=1 and count=DEBOUNCE_CYCLES-1 → HELD.
    - Otherwise count+1.
  - **HELD** (clean=1):
    - btn_sync=0 → RELEASE_WAIT with count=0.
    - Otherwise, hold-counter behaviour applies (see auto-repeat).
  - **RELEASE_WAIT** (clean=1):
    - btn_sync=1 → HELD. No pulse; the hold counter restarts from 0.
    - btn_sync=0 and count=DEBOUNCE_CYCLES-1 → IDLE.
    - Otherwise count+1.
- **Outputs on transitions:**
  - Entering HELD from PRESS_WAIT: press_pulse=1 for exactly one cycle, press_count+1 (255→0), hold counter=0.
  - Entering IDLE from RELEASE_WAIT: release_pulse=1 for exactly one cycle.
- **Auto-repeat** (HELD only, repeat_en=1):
  - The hold counter increments each cycle.
  - On reaching HOLD_CYCLES-1 (first repeat) or REPEAT_CYCLES-1 (later repeats), press_pulse=1 for one cycle and the counter restarts at 0 in repeat phase.
  - repeat_en=0 holds the counter at 0 and returns it to the first-repeat phase.
  - Leaving HELD clears it.
- **Outputs are registered:** press_pulse and release_pulse are never both high, and press_pulse never stays high two consecutive cycles.
- **Reset:** s1, btn_sync, the counters and the FSM all clear. State goes to IDLE. clean=0, press_pulse=0, release_pulse=0, press_count=0.

## Timing
- Edge k is the first rising edge that samples btn_in=1 into s1.
- The FSM enters PRESS_WAIT at edge k+2 and HELD at edge k+D+2 (D=DEBOUNCE_CYCLES).
- press_pulse and clean rise in the cycle after edge k+D+2, provided btn_sync stayed 1 throughout.
- Release is symmetric: release_pulse and clean=0 appear in the cycle after edge j+D+2, where edge j first samples btn_in=0.
- A single btn_sync sample of the opposite level during a WAIT state aborts the wait; the full D count restarts on the next attempt.
- First repeat pulse: HOLD_CYCLES cycles after the initial press_pulse. Later repeats: every REPEAT_CYCLES cycles.
- Reset asserted mid-operation takes effect at the next edge, with no pulse emitted.
- If btn_in is still 1 when reset deasserts, a new press requires the full latency and yields press_pulse with press_count=1.
- A release pulse is never produced without a preceding press.

## Test plan
1. Parameters D=4, HOLD=10, REPEAT=3, repeat_en=0; clean high btn_in from edge k → press_pulse high only in the cycle after edge k+6, clean=1 from then, press_count=1.
2. Glitch rejection: btn_in high for 3 edges, low for 1, then high steadily → no pulse during the glitch; press_pulse appears 6 edges after the final rise; press_count=1.
3. Release bounce: from HELD, btn_in low 2 edges then high 2 edges, then low steadily → clean stays 1 through the bounce; a single release_pulse 6 edges after the final fall; no extra press_pulse.
4. Auto-repeat: repeat_en=1, hold the button 40 cycles after the first press_pulse → repeat pulses at +10, +13, +16, …, +37; press_count stays 1.
5. Wrap-around: 256 clean press/release cycles → press_count returns to 0; exactly 256 press_pulse and 256 release_pulse strobes.
6. Reset mid-press: assert reset during PRESS_WAIT and during HELD with btn_in=1 → all outputs 0 after the edge; after deassert with btn_in held, press_pulse after 6 edges and press_count=1.
